// File: rtl/cargo_stop_scheduler_pkg.sv
// Shared definitions for the cargo stop scheduler.
// - state_e   : scheduler FSM encoding, also exported on the debug port
// - dir_match : picks the segment direction flag that matches a request direction
package cargo_stop_scheduler_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_SCAN_O = 3'd1,
    ST_INS_O  = 3'd2,
    ST_SCAN_D = 3'd3,
    ST_INS_D  = 3'd4,
    ST_DONE   = 3'd5
  } state_e;

  // A flat segment has seg_up = seg_dn = 0, so it never matches either direction.
  function automatic logic dir_match(input logic req_up,
                                     input logic seg_up,
                                     input logic seg_dn);
    return req_up ? seg_up : seg_dn;
  endfunction

endpackage

// File: rtl/cargo_stop_scheduler_entry_array.sv
// Stop entry storage for the cargo stop scheduler.
// Entry layout: {eh_origem, tipo, origem, destino}; stop = eh_origem ? origem : destino.
// Ports:
//   clk_i, rst_ni      clock, asynchronous active-low reset (clears every entry)
//   ins_en_i           insert ins_entry_i at ins_slot_i, entries slot.. shift up by one
//   ins_slot_i         insert position (0 .. DEPTH-1)
//   ins_entry_i        entry to write
//   pop_en_i           shift all entries down by one, top entry cleared
//   rd_idx_i           scan pointer k (0 .. DEPTH)
//   stop_k_o           stop floor of entry k (0 when k == DEPTH)
//   stop_km1_o         stop floor of entry k-1 (0 when k == 0)
//   head_o             entry 0
module cargo_stop_scheduler_entry_array #(
  parameter int FLOOR_W = 2,
  parameter int TYPE_W  = 2,
  parameter int DEPTH   = 16,
  parameter int ADDR_W  = 4,
  parameter int ENTRY_W = 1 + TYPE_W + 2 * FLOOR_W
) (
  input  logic               clk_i,
  input  logic               rst_ni,
  input  logic               ins_en_i,
  input  logic [ADDR_W:0]    ins_slot_i,
  input  logic [ENTRY_W-1:0] ins_entry_i,
  input  logic               pop_en_i,
  input  logic [ADDR_W:0]    rd_idx_i,
  output logic [FLOOR_W-1:0] stop_k_o,
  output logic [FLOOR_W-1:0] stop_km1_o,
  output logic [ENTRY_W-1:0] head_o
);

  localparam int IDX_W   = ADDR_W + 1;
  localparam int EH_BIT  = ENTRY_W - 1;
  localparam int ORG_LSB = FLOOR_W;

  logic [ENTRY_W-1:0] mem_q [DEPTH];
  logic [ENTRY_W-1:0] mem_d [DEPTH];
  logic [FLOOR_W-1:0] stop_arr [DEPTH];

  always_comb begin : stop_decode
    for (int i = 0; i < DEPTH; i++) begin
      stop_arr[i] = mem_q[i][EH_BIT] ? mem_q[i][ORG_LSB +: FLOOR_W] : mem_q[i][FLOOR_W-1:0];
    end
  end

  // Entries above count are always zero, so shifting the whole array is harmless.
  always_comb begin : mem_next
    for (int i = 0; i < DEPTH; i++) begin
      mem_d[i] = mem_q[i];
    end
    if (pop_en_i) begin
      for (int i = 0; i < DEPTH - 1; i++) begin
        mem_d[i] = mem_q[i+1];
      end
      mem_d[DEPTH-1] = '0;
    end else if (ins_en_i) begin
      for (int i = 1; i < DEPTH; i++) begin
        if (IDX_W'(i) > ins_slot_i) begin
          mem_d[i] = mem_q[i-1];
        end
      end
      for (int i = 0; i < DEPTH; i++) begin
        if (IDX_W'(i) == ins_slot_i) begin
          mem_d[i] = ins_entry_i;
        end
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin : mem_reg
    if (!rst_ni) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= mem_d[i];
      end
    end
  end

  always_comb begin : read_mux
    stop_k_o   = '0;
    stop_km1_o = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (rd_idx_i == IDX_W'(i)) begin
        stop_k_o = stop_arr[i];
      end
      if (rd_idx_i == IDX_W'(i + 1)) begin
        stop_km1_o = stop_arr[i];
      end
    end
  end

  assign head_o = mem_q[0];

endmodule

// File: rtl/cargo_stop_scheduler.sv
// Cargo stop scheduler: ordered list of elevator stops with ride-share insertion.
// A new request's pickup and drop are inserted at the first compatible position
// (strictly inside a same-direction segment, or right after an equal stop),
// otherwise appended. The head entry is the next stop to serve.
// Ports:
//   clock, reset        clock, asynchronous active-low reset
//   andar_atual         current cabin floor, acts as the stop before slot 0
//   req_valid/req_ready request handshake; a request transfers on a cycle where both are 1
//   req_origin/destino/tipo  request fields, latched on transfer
//   ins_done            1-cycle pulse when the request has been handled
//   ins_rejected        with ins_done: origin == destino, nothing stored
//   pop/pop_ready       head served; honoured only while pop_ready = 1 and count != 0
//   head_valid, head_eh_origem, head_tipo, head_andar  head entry view
//   count               occupied entries
//   fsm_state           scheduler FSM state (debug)
module cargo_stop_scheduler
  import cargo_stop_scheduler_pkg::*;
#(
  parameter int FLOOR_W = 2,
  parameter int TYPE_W  = 2,
  parameter int DEPTH   = 16,
  parameter int ADDR_W  = 4
) (
  input  logic               clock,
  input  logic               reset,
  input  logic [FLOOR_W-1:0] andar_atual,
  input  logic               req_valid,
  output logic               req_ready,
  input  logic [FLOOR_W-1:0] req_origin,
  input  logic [FLOOR_W-1:0] req_destino,
  input  logic [TYPE_W-1:0]  req_tipo,
  output logic               ins_done,
  output logic               ins_rejected,
  input  logic               pop,
  output logic               pop_ready,
  output logic               head_valid,
  output logic               head_eh_origem,
  output logic [TYPE_W-1:0]  head_tipo,
  output logic [FLOOR_W-1:0] head_andar,
  output logic [ADDR_W:0]    count,
  output state_e             fsm_state
);

  localparam int ENTRY_W = 1 + TYPE_W + 2 * FLOOR_W;
  localparam int IDX_W   = ADDR_W + 1;
  localparam logic [IDX_W-1:0] MAX_ACCEPT = IDX_W'(DEPTH - 2);
  localparam logic [IDX_W-1:0] IDX_ONE    = IDX_W'(1);

  state_e              state_q, state_d;
  logic [IDX_W-1:0]    k_q, k_d;
  logic [IDX_W-1:0]    count_q, count_d;
  logic [IDX_W-1:0]    slot_q, slot_d;
  logic [FLOOR_W-1:0]  org_q, org_d;
  logic [FLOOR_W-1:0]  dst_q, dst_d;
  logic [TYPE_W-1:0]   tipo_q, tipo_d;
  logic                rej_q, rej_d;

  logic                accept, pop_fire, scanning, ins_en;
  logic [FLOOR_W-1:0]  stop_k, stop_km1, prev_stop, tgt;
  logic                req_up, seg_up, seg_dn;
  logic                hit_between, hit_equal, at_end, hit;
  logic [ENTRY_W-1:0]  ins_entry, head_entry;

  assign accept   = (state_q == ST_IDLE) && req_valid && req_ready;
  assign pop_fire = (state_q == ST_IDLE) && pop && (count_q != '0);
  assign scanning = (state_q == ST_SCAN_O) || (state_q == ST_SCAN_D);
  assign ins_en   = (state_q == ST_INS_O) || (state_q == ST_INS_D);
  assign ins_entry = {(state_q == ST_INS_O), tipo_q, org_q, dst_q};

  cargo_stop_scheduler_entry_array #(
    .FLOOR_W (FLOOR_W),
    .TYPE_W  (TYPE_W),
    .DEPTH   (DEPTH),
    .ADDR_W  (ADDR_W),
    .ENTRY_W (ENTRY_W)
  ) u_entries (
    .clk_i       (clock),
    .rst_ni      (reset),
    .ins_en_i    (ins_en),
    .ins_slot_i  (slot_q),
    .ins_entry_i (ins_entry),
    .pop_en_i    (pop_fire),
    .rd_idx_i    (k_q),
    .stop_k_o    (stop_k),
    .stop_km1_o  (stop_km1),
    .head_o      (head_entry)
  );

  // Ride-share comparators for entry k. andar_atual is only looked at for k == 0.
  always_comb begin : compare
    prev_stop   = (k_q == '0) ? andar_atual : stop_km1;
    tgt         = (state_q == ST_SCAN_D) ? dst_q : org_q;
    req_up      = dst_q > org_q;
    seg_up      = stop_k > prev_stop;
    seg_dn      = stop_k < prev_stop;
    hit_between = req_up ? ((prev_stop < tgt) && (tgt < stop_k))
                         : ((stop_k < tgt) && (tgt < prev_stop));
    hit_equal   = (stop_k == tgt) && (dir_match(req_up, seg_up, seg_dn) || (k_q == '0));
    at_end      = (k_q == count_q);
    hit         = at_end || hit_between || hit_equal;
  end

  // FSM: state register
  always_ff @(posedge clock or negedge reset) begin : fsm_reg
    if (!reset) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM: next state
  always_comb begin : fsm_next
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          state_d = (req_origin == req_destino) ? ST_DONE : ST_SCAN_O;
        end
      end
      ST_SCAN_O: if (hit) state_d = ST_INS_O;
      ST_INS_O:  state_d = ST_SCAN_D;
      ST_SCAN_D: if (hit) state_d = ST_INS_D;
      ST_INS_D:  state_d = ST_DONE;
      ST_DONE:   state_d = ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase
  end

  // FSM: outputs
  always_comb begin : fsm_out
    req_ready    = (state_q == ST_IDLE) && (count_q <= MAX_ACCEPT);
    pop_ready    = (state_q == ST_IDLE);
    ins_done     = (state_q == ST_DONE);
    ins_rejected = (state_q == ST_DONE) && rej_q;
    fsm_state    = state_q;
  end

  // Datapath next values. An equal-stop hit lands after stop k so same-floor
  // stops coalesce; the drop scan restarts just past the pickup slot.
  always_comb begin : dp_next
    k_d     = k_q;
    count_d = count_q;
    slot_d  = slot_q;
    org_d   = org_q;
    dst_d   = dst_q;
    tipo_d  = tipo_q;
    rej_d   = rej_q;
    if (accept) begin
      org_d  = req_origin;
      dst_d  = req_destino;
      tipo_d = req_tipo;
      rej_d  = (req_origin == req_destino);
      k_d    = '0;
    end
    if (scanning) begin
      if (hit) begin
        if (at_end) begin
          slot_d = count_q;
        end else if (hit_between) begin
          slot_d = k_q;
        end else begin
          slot_d = k_q + IDX_ONE;
        end
      end else begin
        k_d = k_q + IDX_ONE;
      end
    end
    if (state_q == ST_INS_O) begin
      k_d = slot_q + IDX_ONE;
    end
    if (pop_fire) begin
      count_d = count_q - IDX_ONE;
    end else if (ins_en) begin
      count_d = count_q + IDX_ONE;
    end
  end

  always_ff @(posedge clock or negedge reset) begin : dp_reg
    if (!reset) begin
      k_q     <= '0;
      count_q <= '0;
      slot_q  <= '0;
      org_q   <= '0;
      dst_q   <= '0;
      tipo_q  <= '0;
      rej_q   <= 1'b0;
    end else begin
      k_q     <= k_d;
      count_q <= count_d;
      slot_q  <= slot_d;
      org_q   <= org_d;
      dst_q   <= dst_d;
      tipo_q  <= tipo_d;
      rej_q   <= rej_d;
    end
  end

  assign count          = count_q;
  assign head_valid     = (count_q != '0);
  assign head_eh_origem = head_entry[ENTRY_W-1];
  assign head_tipo      = head_entry[2*FLOOR_W +: TYPE_W];
  assign head_andar     = head_entry[ENTRY_W-1] ? head_entry[FLOOR_W +: FLOOR_W]
                                                : head_entry[FLOOR_W-1:0];

endmodule
